// File: rtl/data_memory_sync.sv
// Clocked MIPS MEM-stage data memory: big-endian byte/half/word access, 1-cycle response, error pulse.
// Define DMEM_INIT_PATTERN_EN to preload word i = INIT_BASE + i*INIT_STEP after every reset.
module data_memory_sync #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] INIT_BASE = 32'd5,
    parameter logic [31:0] INIT_STEP = 32'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic        rd_valid,
    output logic [31:0] data_out,
    output logic        error
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

`ifdef DMEM_INIT_PATTERN_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  init_idx_q, init_idx_d;
    logic              req_ready_q, req_ready_d;
    logic              rd_valid_q, rd_valid_d;
    logic              error_q, error_d;
    logic [31:0]       data_out_q, data_out_d;
    logic [31:0]       mem_q [DEPTH];

    logic              accept;
    logic              req_err;
    logic              out_of_range;
    logic [1:0]        lane;
    logic [IDX_W-1:0]  mem_idx;
    logic [4:0]        byte_shift;
    logic [4:0]        half_shift;
    logic [31:0]       rd_word;
    logic [31:0]       byte_word;
    logic [31:0]       half_word;
    logic [31:0]       wr_word;
    logic [31:0]       load_val;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [31:0]       mem_wdata;

    assign accept    = req_valid & req_ready_q;
    assign req_ready = req_ready_q;
    assign rd_valid  = rd_valid_q;
    assign data_out  = data_out_q;
    assign error     = error_q;

    // Address decode, lane extraction and read-modify-write merge for the current request.
    always_comb begin
        lane         = address[1:0];
        out_of_range = (address[31:2] >= 30'(DEPTH));
        mem_idx      = address[IDX_W+1:2];
        req_err      = (mem_read == mem_write)
                     || (size == 2'b11)
                     || ((size == 2'b01) && address[0])
                     || ((size == 2'b10) && (address[1:0] != 2'b00))
                     || out_of_range;
        rd_word      = out_of_range ? '0 : mem_q[mem_idx];

        // Big-endian: lane 0 is the most significant byte, so shift by (3 - lane) bytes.
        byte_shift   = {~lane, 3'b000};
        half_shift   = {~lane[1], 4'b0000};
        byte_word    = rd_word >> byte_shift;
        half_word    = rd_word >> half_shift;

        load_val = rd_word;
        wr_word  = data_in;
        case (size)
            2'b00: begin
                load_val = load_unsigned ? {24'h0, byte_word[7:0]}
                                         : {{24{byte_word[7]}}, byte_word[7:0]};
                wr_word  = (rd_word & ~(32'h0000_00FF << byte_shift))
                         | ({24'h0, data_in[7:0]} << byte_shift);
            end
            2'b01: begin
                load_val = load_unsigned ? {16'h0, half_word[15:0]}
                                         : {{16{half_word[15]}}, half_word[15:0]};
                wr_word  = (rd_word & ~(32'h0000_FFFF << half_shift))
                         | ({16'h0, data_in[15:0]} << half_shift);
            end
            default: begin
                load_val = rd_word;
                wr_word  = data_in;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        mem_we      = 1'b0;
        mem_waddr   = mem_idx;
        mem_wdata   = wr_word;
        req_ready_d = (state_q == ST_IDLE);
        rd_valid_d  = accept;
        error_d     = accept & req_err;
        data_out_d  = data_out_q;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = init_idx_q;
                mem_wdata = INIT_BASE + 32'(init_idx_q) * INIT_STEP;
                if (init_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    init_idx_d = init_idx_q + 1'b1;
                end
            end
            default: begin
                mem_we = accept & mem_write & ~req_err;
            end
        endcase

        if (accept) begin
            if (req_err) begin
                data_out_d = '0;
            end else if (mem_read) begin
                data_out_d = load_val;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            init_idx_q  <= '0;
            req_ready_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            error_q     <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            req_ready_q <= req_ready_d;
            rd_valid_q  <= rd_valid_d;
            error_q     <= error_d;
            data_out_q  <= data_out_d;
        end
    end

    // Storage keeps its contents through reset; only INIT rewrites it.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_data_memory_sync.sv
// Randomised scoreboard bench for data_memory_sync, byte-addressed big-endian reference model.
// Build with or without DMEM_INIT_PATTERN_EN; expectations follow the same macro.
module tb_data_memory_sync;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'd5;
    localparam logic [31:0] STEP  = 32'd5;
`ifdef DMEM_INIT_PATTERN_EN
    localparam int EXP_LAT = DEPTH + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        rd_valid;
    logic [31:0] data_out;
    logic        error;

    data_memory_sync #(
        .DEPTH(DEPTH),
        .INIT_BASE(BASE),
        .INIT_STEP(STEP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .mem_write(mem_write),
        .mem_read(mem_read),
        .size(size),
        .load_unsigned(load_unsigned),
        .address(address),
        .data_in(data_in),
        .rd_valid(rd_valid),
        .data_out(data_out),
        .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mb [DEPTH*4];
    logic [31:0] model_dout;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        model_dout = '0;
`ifdef DMEM_INIT_PATTERN_EN
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [31:0] w;
            w = BASE + 32'(i) * STEP;
            mb[4*i]   = w[31:24];
            mb[4*i+1] = w[23:16];
            mb[4*i+2] = w[15:8];
            mb[4*i+3] = w[7:0];
        end
`endif
    endtask

    // Drive one cycle of request; model decides outcome from the spec rules on byte addresses.
    task automatic issue(input logic v, input logic w, input logic r, input logic [1:0] sz,
                         input logic u, input logic [31:0] a, input logic [31:0] d,
                         input logic use_lit, input logic [31:0] lit);
        logic acc;
        logic err;
        int   nb;
        logic [31:0] val;
        exp_t e;
        req_valid = v; mem_write = w; mem_read = r; size = sz;
        load_unsigned = u; address = a; data_in = d;
        acc = v && (req_ready === 1'b1);
        if (acc) begin
            nb  = 1 << sz;
            err = (r == w) || (sz == 2'd3) || (sz == 2'd1 && a[0])
                || (sz == 2'd2 && a[1:0] != 2'd0) || ((a >> 2) >= DEPTH);
            if (err) begin
                model_dout = '0;
                e.err = 1'b1; e.data = '0;
            end else if (w) begin
                for (int k = 0; k < nb; k++) begin
                    mb[int'(a) + k] = 8'((d >> (8 * (nb - 1 - k))) & 32'hFF);
                end
                e.err = 1'b0; e.data = model_dout;
            end else begin
                val = '0;
                for (int k = 0; k < nb; k++) val = (val << 8) | 32'(mb[int'(a) + k]);
                if (!u && sz == 2'd0 && val >= 32'h80)   val = val | 32'hFFFF_FF00;
                if (!u && sz == 2'd1 && val >= 32'h8000) val = val | 32'hFFFF_0000;
                model_dout = use_lit ? lit : val;
                e.err = 1'b0; e.data = model_dout;
            end
        end
        @(posedge clk);
        if (acc) sb.push_back(e);
        #1;
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic load(input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic use_lit, input logic [31:0] lit);
        issue(1'b1, 1'b0, 1'b1, sz, u, a, 32'h0, use_lit, lit);
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        issue(1'b1, 1'b1, 1'b0, sz, 1'b0, a, d, 1'b0, 32'h0);
    endtask

    task automatic release_and_count();
        int n;
        reset = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_latency", 32'(n), 32'(EXP_LAT));
    endtask

    // Monitor: every rd_valid must match the oldest expectation; an expectation must be met the next cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("stray_rd_valid", 32'(rd_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_error", 32'(error), 32'(e.err));
                    check("rsp_data", data_out, e.data);
                end
            end else if (sb.size() != 0) begin
                check("rsp_latency", 32'(rd_valid), 32'h1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; mem_write = 1'b0; mem_read = 1'b0; size = 2'd0;
        load_unsigned = 1'b0; address = '0; data_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_data_out", data_out, 32'h0);
        check("rst_error", 32'(error), 32'h0);
        release_and_count();

`ifdef DMEM_INIT_PATTERN_EN
        load(2'd2, 1'b0, 32'h0, 1'b1, 32'd5);
        load(2'd2, 1'b0, 32'h3C, 1'b1, 32'd80);
`endif
        for (int i = 0; i < int'(DEPTH); i++) store(2'd2, 32'(4 * i), $urandom);

        store(2'd2, 32'h8, 32'h80FF_7F01);
        load(2'd0, 1'b0, 32'h8, 1'b1, 32'hFFFF_FF80);
        load(2'd0, 1'b1, 32'hB, 1'b1, 32'h0000_0001);
        load(2'd1, 1'b0, 32'hA, 1'b1, 32'h0000_7F01);

        store(2'd2, 32'h4, 32'h1122_3344);
        store(2'd0, 32'h5, 32'h0000_00AA);
        load(2'd2, 1'b0, 32'h4, 1'b1, 32'h11AA_3344);

        load(2'd2, 1'b0, 32'h2, 1'b0, 32'h0);
        load(2'd1, 1'b0, 32'h1, 1'b0, 32'h0);
        load(2'd2, 1'b0, 32'h40, 1'b0, 32'h0);
        issue(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF, 1'b0, 32'h0);
        issue(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0);
        load(2'd2, 1'b0, 32'h8, 1'b1, 32'h80FF_7F01);
        load(2'd2, 1'b0, 32'h4, 1'b1, 32'h11AA_3344);

        store(2'd2, 32'hC, 32'hCAFE_F00D);
        load(2'd2, 1'b0, 32'hC, 1'b1, 32'hCAFE_F00D);
        idle();

        for (int i = 0; i < 400; i++) begin
            logic v, w, r, u;
            logic [1:0] sz, ln;
            logic [31:0] a, idx;
            int op;
            v  = ($urandom_range(0, 9) != 0);
            op = $urandom_range(0, 19);
            if (op == 0) begin
                r = 1'($urandom_range(0, 1)); w = r;
            end else begin
                r = (op < 10); w = !r;
            end
            sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            u   = 1'($urandom_range(0, 1));
            idx = 32'($urandom_range(0, DEPTH + 1));
            ln  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) ln = {ln[1], 1'b0};
                if (sz == 2'd2) ln = 2'd0;
            end
            a = {idx[29:0], ln};
            if ($urandom_range(0, 31) == 0) a = $urandom;
            issue(v, w, r, sz, u, a, $urandom, 1'b0, 32'h0);
        end
        idle();

        load(2'd2, 1'b0, 32'h0, 1'b0, 32'h0);
        reset = 1'b1;
        req_valid = 1'b0;
        sb.delete();
        #1;
        check("drop_rd_valid", 32'(rd_valid), 32'h0);
        check("drop_ready", 32'(req_ready), 32'h0);
        check("drop_data_out", data_out, 32'h0);
        model_reset();
        @(posedge clk); #1;
        release_and_count();
        for (int i = 0; i < int'(DEPTH); i += 5) load(2'd2, 1'b0, 32'(4 * i), 1'b0, 32'h0);
        idle();

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("init_mid_ready", 32'(req_ready), 32'(7 >= EXP_LAT));
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        release_and_count();
`ifdef DMEM_INIT_PATTERN_EN
        load(2'd2, 1'b0, 32'h1C, 1'b1, 32'd40);
`endif
        for (int i = 0; i < int'(DEPTH); i += 3) load(2'd2, 1'b0, 32'(4 * i), 1'b0, 32'h0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
